vga_timing_gen: RTL and testbench

- Generates raster scan timing for the pixel shaders: hcount/vcount/enable/timer into shader blocks, and HSYNC/VSYNC/DE to the VGA pins.
- It is the driving end of the shader interface.
- Default mode is SVGA 800x600@60 (40 MHz pixel rate), advanced by a pixel clock-enable.
- Sync/DE are delayed by a programmable pipeline so they align with the shaders' registered RGB.

---
 rtl/vga_timing_pkg.sv | 38 +++
 rtl/vga_timing_gen_if.sv | 31 +++
 rtl/vga_timing_gen_sync_delay_line.sv | 36 +++
 rtl/vga_timing_gen.sv | 98 +++++++++
 tb/tb_vga_timing_gen.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants, phase encoding and phase classifier
// for the VGA timing generator and its shader consumers.
package vga_timing_pkg;

    // Default mode: SVGA 800x600@60, 40 MHz pixel rate
    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_H_SYNC   = 128;
    localparam int DEF_H_BP     = 88;
    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FP     = 1;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 23;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int TIMER_W = 16;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_e;

    // Same ordering applies to both axes: active, front porch, sync, back porch
    function automatic phase_e get_phase(input int unsigned pos,
                                         input int unsigned active,
                                         input int unsigned fp,
                                         input int unsigned sync);
        if (pos < active)             return PH_ACTIVE;
        if (pos < active + fp)        return PH_FRONT;
        if (pos < active + fp + sync) return PH_SYNC;
        return PH_BACK;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Shader-side raster interface: the timing generator is the master and
// drives position/enable/timer plus the VGA pin signals.
interface vga_timing_gen_if #(
    parameter int CW = 11
);
    import vga_timing_pkg::*;

    logic               pix_ce;
    logic [CW-1:0]      hcount;
    logic [CW-1:0]      vcount;
    logic               enable;
    logic               line_start;
    logic               frame_start;
    logic [TIMER_W-1:0] timer;
    logic               vga_hsync;
    logic               vga_vsync;
    logic               vga_de;

    modport master (
        input  pix_ce,
        output hcount, vcount, enable, line_start, frame_start, timer,
        output vga_hsync, vga_vsync, vga_de
    );

    modport slave (
        input pix_ce,
        input hcount, vcount, enable, line_start, frame_start, timer,
        input vga_hsync, vga_vsync, vga_de
    );

endinterface

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Clock-enabled shift register that delays sync/DE so they line up with the
// shaders' registered RGB. DEPTH=0 is a pure wire.
module sync_delay_line #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign q = d;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage [DEPTH];

            // NOTE: these stages feed the VGA pins, so unlike a data buffer they are
            // reset; otherwise sync would glitch for DEPTH ticks after reset release.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
                end else if (ce) begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters with registered enable,
// line/frame pulses and frame timer, plus delayed HSYNC/VSYNC/DE.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CW       = 11,
    parameter int PIPE     = 1
) (
    input  logic             clock,
    input  logic             reset,
    vga_timing_gen_if.master bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    logic [CW-1:0]      hcount_q, vcount_q;
    logic [CW-1:0]      h_next, v_next;
    logic               enable_q, line_start_q, frame_start_q;
    logic               hsync_q, vsync_q;
    logic [TIMER_W-1:0] timer_q;
    phase_e             h_phase, v_phase;
    logic [2:0]         pipe_q;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        h_next = hcount_q + 1'b1;
        v_next = vcount_q;
        if (hcount_q == H_LAST) begin
            h_next = '0;
            v_next = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
        end
        h_phase = get_phase(32'(h_next), H_ACTIVE, H_FP, H_SYNC);
        v_phase = get_phase(32'(v_next), V_ACTIVE, V_FP, V_SYNC);
    end

    // Flags are computed from the next position so they describe the same
    // hcount/vcount that is presented alongside them.
    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hcount_q      <= H_LAST;
            vcount_q      <= V_LAST;
            enable_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            timer_q       <= '0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
        end else if (bus.pix_ce) begin
            hcount_q      <= h_next;
            vcount_q      <= v_next;
            enable_q      <= (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
            line_start_q  <= (h_next == '0);
            frame_start_q <= (h_next == '0) && (v_next == '0);
            hsync_q       <= (h_phase == PH_SYNC);
            vsync_q       <= (v_phase == PH_SYNC);
            if ((h_next == '0) && (v_next == '0)) timer_q <= timer_q + 1'b1;
        end
    end

    // Delay stages carry active-high levels; pin polarity is applied after them
    sync_delay_line #(
        .WIDTH   (3),
        .DEPTH   (PIPE),
        .RST_VAL (3'b000)
    ) u_delay (
        .clock (clock),
        .reset (reset),
        .ce    (bus.pix_ce),
        .d     ({hsync_q, vsync_q, enable_q}),
        .q     (pipe_q)
    );

    assign bus.hcount      = hcount_q;
    assign bus.vcount      = vcount_q;
    assign bus.enable      = enable_q;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;
    assign bus.timer       = timer_q;
    assign bus.vga_hsync   = HS_POL ? pipe_q[2] : ~pipe_q[2];
    assign bus.vga_vsync   = VS_POL ? pipe_q[1] : ~pipe_q[1];
    assign bus.vga_de      = pipe_q[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: default SVGA timing on the first line,
// and a reduced 16x11 mode (PIPE=0 and PIPE=3/negative sync) over whole frames.
module tb_vga_timing_gen;

    // Reduced mode: 8+2+3+3 = 16 pixels/line, 6+1+2+2 = 11 lines, 176 ticks/frame
    localparam int S_HA = 8, S_HFP = 2, S_HS = 3, S_HBP = 3;
    localparam int S_VA = 6, S_VFP = 1, S_VS = 2, S_VBP = 2;
    localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;
    localparam int S_VT = S_VA + S_VFP + S_VS + S_VBP;
    localparam int N_DEF = 12;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        en;
        logic        ls;
        logic        fs;
        logic [15:0] timer;
        logic        hs;
        logic        vs;
        logic        de;
    } obs_t;

    logic clock;
    logic reset;
    logic pix_ce;

    int tests = 0;
    int fails = 0;
    int n     = 0;
    int di    = 0;

    obs_t q_a[$], q_b[$], q_def[$];
    obs_t obs_a, obs_b, obs_def;
    int   def_tick [N_DEF];
    obs_t def_exp  [N_DEF];

    vga_timing_gen_if #(.CW(11)) bus_def ();
    vga_timing_gen_if #(.CW(5))  bus_a ();
    vga_timing_gen_if #(.CW(5))  bus_b ();

    assign bus_def.pix_ce = pix_ce;
    assign bus_a.pix_ce   = pix_ce;
    assign bus_b.pix_ce   = pix_ce;

    vga_timing_gen dut_def (
        .clock (clock),
        .reset (reset),
        .bus   (bus_def)
    );

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(5), .PIPE(0)
    ) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(5), .PIPE(3)
    ) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    assign obs_def = {bus_def.hcount, bus_def.vcount, bus_def.enable, bus_def.line_start,
                      bus_def.frame_start, bus_def.timer, bus_def.vga_hsync,
                      bus_def.vga_vsync, bus_def.vga_de};
    assign obs_a = {11'(bus_a.hcount), 11'(bus_a.vcount), bus_a.enable, bus_a.line_start,
                    bus_a.frame_start, bus_a.timer, bus_a.vga_hsync, bus_a.vga_vsync,
                    bus_a.vga_de};
    assign obs_b = {11'(bus_b.hcount), 11'(bus_b.vcount), bus_b.enable, bus_b.line_start,
                    bus_b.frame_start, bus_b.timer, bus_b.vga_hsync, bus_b.vga_vsync,
                    bus_b.vga_de};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected outputs of the reduced mode after n pixel ticks since reset release
    function automatic obs_t small_exp(input int n_tick, input int pipe, input bit hpol, input bit vpol);
        obs_t o;
        int h, v, k;
        bit hs, vs, de;
        o = '0;
        if (n_tick > 0) begin
            h = (n_tick - 1) % S_HT;
            v = ((n_tick - 1) / S_HT) % S_VT;
            o.h     = 11'(h);
            o.v     = 11'(v);
            o.en    = (h < S_HA) && (v < S_VA);
            o.ls    = (h == 0);
            o.fs    = (h == 0) && (v == 0);
            o.timer = 16'((n_tick - 1) / (S_HT * S_VT) + 1);
        end else begin
            o.h = 11'(S_HT - 1);
            o.v = 11'(S_VT - 1);
        end
        k  = n_tick - pipe;
        hs = 1'b0;
        vs = 1'b0;
        de = 1'b0;
        if (k > 0) begin
            h  = (k - 1) % S_HT;
            v  = ((k - 1) / S_HT) % S_VT;
            hs = (h >= S_HA + S_HFP) && (h < S_HA + S_HFP + S_HS);
            vs = (v >= S_VA + S_VFP) && (v < S_VA + S_VFP + S_VS);
            de = (h < S_HA) && (v < S_VA);
        end
        o.hs = hpol ? hs : !hs;
        o.vs = vpol ? vs : !vs;
        o.de = de;
        return o;
    endfunction

    // Hand-computed landmark on the first SVGA lines (timer=1, vsync pin low)
    function automatic obs_t dv(input int h, input int v, input bit en, input bit ls,
                                input bit fs, input bit hs, input bit de);
        obs_t o;
        o       = '0;
        o.h     = 11'(h);
        o.v     = 11'(v);
        o.en    = en;
        o.ls    = ls;
        o.fs    = fs;
        o.timer = 16'd1;
        o.hs    = hs;
        o.de    = de;
        return o;
    endfunction

    // One clock with pix_ce=ce; expected responses are queued right after the edge
    task automatic cyc(input bit ce);
        pix_ce = ce;
        @(posedge clock);
        if (ce && !reset) begin
            n++;
            if (di < N_DEF && def_tick[di] == n) begin
                q_def.push_back(def_exp[di]);
                di++;
            end
        end
        q_a.push_back(small_exp(n, 0, 1'b1, 1'b1));
        q_b.push_back(small_exp(n, 3, 1'b0, 1'b0));
        @(negedge clock);
        #1;
    endtask

    // Monitor: outputs are presented every clock, compared on the falling edge
    initial begin
        forever begin
            @(negedge clock);
            if (q_a.size() > 0)   check("small_pipe0", 64'(obs_a), 64'(q_a.pop_front()));
            if (q_b.size() > 0)   check("small_pipe3_negpol", 64'(obs_b), 64'(q_b.pop_front()));
            if (q_def.size() > 0) check("svga_landmark", 64'(obs_def), 64'(q_def.pop_front()));
        end
    end

    initial begin
        def_tick = '{1, 2, 800, 801, 802, 841, 842, 969, 970, 1056, 1057, 1058};
        def_exp[0]  = dv(0,    0, 1, 1, 1, 0, 0);
        def_exp[1]  = dv(1,    0, 1, 0, 0, 0, 1);
        def_exp[2]  = dv(799,  0, 1, 0, 0, 0, 1);
        def_exp[3]  = dv(800,  0, 0, 0, 0, 0, 1);
        def_exp[4]  = dv(801,  0, 0, 0, 0, 0, 0);
        def_exp[5]  = dv(840,  0, 0, 0, 0, 0, 0);
        def_exp[6]  = dv(841,  0, 0, 0, 0, 1, 0);
        def_exp[7]  = dv(968,  0, 0, 0, 0, 1, 0);
        def_exp[8]  = dv(969,  0, 0, 0, 0, 0, 0);
        def_exp[9]  = dv(1055, 0, 0, 0, 0, 0, 0);
        def_exp[10] = dv(0,    1, 1, 1, 0, 0, 0);
        def_exp[11] = dv(1,    1, 1, 0, 0, 0, 1);

        reset  = 1'b1;
        pix_ce = 1'b0;
        repeat (5) cyc(1'b0);
        check("reset_svga",  64'(obs_def), 64'({11'd1055, 11'd627, 3'b000, 16'd0, 3'b000}));
        check("reset_pipe0", 64'(obs_a),   64'({11'd15, 11'd10, 3'b000, 16'd0, 3'b000}));
        check("reset_pipe3", 64'(obs_b),   64'({11'd15, 11'd10, 3'b000, 16'd0, 3'b110}));

        // Continuous ticks: first SVGA line plus six reduced frames
        reset = 1'b0;
        repeat (1100) cyc(1'b1);

        // Asynchronous reset in the middle of a clock period, mid-frame
        reset = 1'b1;
        #1;
        check("async_reset_svga",  64'(obs_def), 64'({11'd1055, 11'd627, 3'b000, 16'd0, 3'b000}));
        check("async_reset_pipe0", 64'(obs_a),   64'({11'd15, 11'd10, 3'b000, 16'd0, 3'b000}));
        check("async_reset_pipe3", 64'(obs_b),   64'({11'd15, 11'd10, 3'b000, 16'd0, 3'b110}));
        n  = 0;
        di = 0;
        repeat (2) cyc(1'b1);
        reset = 1'b0;

        // pix_ce alternating: outputs must hold through the idle clocks
        for (int i = 0; i < 400; i++) cyc(i % 2 == 0);

        @(negedge clock);
        #1;
        check("scoreboard_drained", 64'(q_a.size() + q_b.size() + q_def.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
